// File: rtl/uart_loop_pkg.sv
// rtl/uart_loop_pkg.sv - shared types, abort codes and defaults for the UART loopback sequencer
package uart_loop_pkg;

    localparam int         DEF_NUM_BYTES  = 256;
    localparam int         DEF_RX_TIMEOUT = 50000;
    localparam logic [7:0] DEF_SEED       = 8'h00;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_UNF     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RX,
        ST_WRITE,
        ST_DRAIN,
        ST_CHECK,
        ST_FIN
    } loop_state_t;

endpackage

// File: rtl/uart_loop_cmp.sv
// rtl/uart_loop_cmp.sv - expected-byte counter, saturating mismatch counter and pass evaluation
module uart_loop_cmp
    import uart_loop_pkg::*;
#(
    parameter int         NUM_BYTES = DEF_NUM_BYTES,
    parameter logic [7:0] SEED      = DEF_SEED,
    localparam int        IW        = $clog2(NUM_BYTES + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          clear,
    input  logic          step,
    input  logic          eval,
    input  logic [7:0]    data,
    input  logic [1:0]    code,
    output logic [IW-1:0] rd_idx,
    output logic [8:0]    err_cnt,
    output logic          pass
);

    logic [7:0] expected;
    logic [8:0] err_cnt_nxt;

    assign expected = SEED + 8'(rd_idx);

    // pass is evaluated on the same edge as the final compare, so it uses the next count
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (step && (data != expected) && (err_cnt != 9'h1FF))
            err_cnt_nxt = err_cnt + 9'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_idx  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (clear) begin
            rd_idx  <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            if (step)
                rd_idx <= rd_idx + IW'(1);
            err_cnt <= err_cnt_nxt;
            if (eval)
                pass <= (err_cnt_nxt == 9'd0) && (code == ERR_NONE);
        end
    end

endmodule

// File: rtl/uart_loop_seq.sv
// rtl/uart_loop_seq.sv - UART self-loopback and FIFO test sequencer
module uart_loop_seq
    import uart_loop_pkg::*;
#(
    parameter int         NUM_BYTES  = DEF_NUM_BYTES,
    parameter int         RX_TIMEOUT = DEF_RX_TIMEOUT,
    parameter logic [7:0] SEED       = DEF_SEED
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_din,
    input  logic       fifo_full,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic [1:0] err_code
);

    localparam int            IW       = $clog2(NUM_BYTES + 1);
    localparam int            TW       = $clog2(RX_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
    localparam logic [IW-1:0] NUM_IDX  = IW'(NUM_BYTES);

    loop_state_t   state;
    logic [IW-1:0] idx;
    logic [IW-1:0] rd_idx;
    logic [TW-1:0] timer;
    logic          fin_go;
    logic [1:0]    fin_code;
    logic          clear;
    logic          step;

    assign clear = (state == ST_IDLE) && start;
    assign step  = (state == ST_CHECK);

    // FIFO strobes follow the registered state so the flag seen is the one at the write/read edge
    assign fifo_wr_en = (state == ST_WRITE) && !fifo_full;
    assign fifo_rd_en = (state == ST_DRAIN) && !fifo_empty;

    always_comb begin
        fin_go   = 1'b0;
        fin_code = ERR_NONE;
        case (state)
            ST_WAIT_RX: if (!rx_done && timer == '0) begin
                fin_go   = 1'b1;
                fin_code = ERR_TIMEOUT;
            end
            ST_WRITE: if (fifo_full) begin
                fin_go   = 1'b1;
                fin_code = ERR_OVF;
            end
            ST_DRAIN: if (fifo_empty && rd_idx < NUM_IDX) begin
                fin_go   = 1'b1;
                fin_code = ERR_UNF;
            end
            ST_CHECK: if (rd_idx == LAST_IDX) begin
                fin_go   = 1'b1;
                fin_code = ERR_NONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            timer    <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            fifo_din <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            tx_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_SEND;
                    busy     <= 1'b1;
                    idx      <= '0;
                    err_code <= ERR_NONE;
                end
                ST_SEND: if (!tx_busy) begin
                    tx_en   <= 1'b1;
                    tx_data <= SEED + 8'(idx);
                    timer   <= TW'(RX_TIMEOUT);
                    state   <= ST_WAIT_RX;
                end
                ST_WAIT_RX: begin
                    if (rx_done) begin
                        fifo_din <= rx_data;
                        state    <= ST_WRITE;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_WRITE: if (!fifo_full) begin
                    idx   <= idx + IW'(1);
                    state <= (idx == LAST_IDX) ? ST_DRAIN : ST_SEND;
                end
                ST_DRAIN: state <= ST_CHECK;
                ST_CHECK: state <= ST_DRAIN;
                ST_FIN:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            // done and the abort code appear in the FIN cycle itself
            if (fin_go) begin
                state    <= ST_FIN;
                done     <= 1'b1;
                busy     <= 1'b0;
                err_code <= fin_code;
            end
        end
    end

    uart_loop_cmp #(
        .NUM_BYTES (NUM_BYTES),
        .SEED      (SEED)
    ) u_cmp (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (clear),
        .step      (step),
        .eval      (fin_go),
        .data      (fifo_dout),
        .code      (fin_code),
        .rd_idx    (rd_idx),
        .err_cnt   (err_cnt),
        .pass      (pass)
    );

endmodule

// File: tb/tb_uart_loop_seq.sv
// tb/tb_uart_loop_seq.sv - directed bench with loopback and FIFO models for uart_loop_seq
module tb_uart_loop_seq;

    localparam int LB_DELAY = 10;
    localparam int TX_BUSY  = 14;

    logic sys_clk, sys_rst_n, clr, sel;
    logic start_a, start_b;
    logic tx_busy, rx_done, fifo_full, fifo_empty;
    logic [7:0] rx_data, fifo_dout;

    logic       a_tx_en, a_wr, a_rd, a_busy, a_done, a_pass;
    logic [7:0] a_tx_data, a_din;
    logic [8:0] a_err_cnt;
    logic [1:0] a_err_code;
    logic       b_tx_en, b_wr, b_rd, b_busy, b_done, b_pass;
    logic [7:0] b_tx_data, b_din;
    logic [8:0] b_err_cnt;
    logic [1:0] b_err_code;

    logic       tx_en, fifo_wr_en, fifo_rd_en, busy, done, pass;
    logic [7:0] tx_data, fifo_din;
    logic [8:0] err_cnt;
    logic [1:0] err_code;

    int vec_cnt = 0;
    int mis_cnt = 0;

    int stop_after, corrupt_idx, drop_idx, full_at;
    logic [7:0] corrupt_val, exp_seed;

    int cyc = 0;
    int busy_cnt, lb_cnt, wr_cnt, rd_cnt, txen_cnt, done_cnt;
    int din_err, lat_err, txb_err, txen_cyc, done_cyc, rx_cyc;
    logic lb_on, prev_rx, prev_busy;
    logic [7:0] lb_byte;
    logic [8:0] wp, rp;
    logic [7:0] mem [256];
    logic [7:0] txlog [4];

    uart_loop_seq #(.NUM_BYTES(256), .RX_TIMEOUT(1000), .SEED(8'h00)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_a),
        .tx_en(a_tx_en), .tx_data(a_tx_data), .tx_busy(tx_busy),
        .rx_done(rx_done), .rx_data(rx_data),
        .fifo_wr_en(a_wr), .fifo_din(a_din), .fifo_full(fifo_full),
        .fifo_rd_en(a_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt), .err_code(a_err_code)
    );

    uart_loop_seq #(.NUM_BYTES(4), .RX_TIMEOUT(1000), .SEED(8'hFE)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b),
        .tx_en(b_tx_en), .tx_data(b_tx_data), .tx_busy(tx_busy),
        .rx_done(rx_done), .rx_data(rx_data),
        .fifo_wr_en(b_wr), .fifo_din(b_din), .fifo_full(fifo_full),
        .fifo_rd_en(b_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt), .err_code(b_err_code)
    );

    assign tx_en      = sel ? b_tx_en    : a_tx_en;
    assign tx_data    = sel ? b_tx_data  : a_tx_data;
    assign fifo_wr_en = sel ? b_wr       : a_wr;
    assign fifo_din   = sel ? b_din      : a_din;
    assign fifo_rd_en = sel ? b_rd       : a_rd;
    assign busy       = sel ? b_busy     : a_busy;
    assign done       = sel ? b_done     : a_done;
    assign pass       = sel ? b_pass     : a_pass;
    assign err_cnt    = sel ? b_err_cnt  : a_err_cnt;
    assign err_code   = sel ? b_err_code : a_err_code;

    assign fifo_empty = (wp == rp);
    assign fifo_full  = ((full_at >= 0) && (wr_cnt >= full_at)) || (9'(wp - rp) == 9'd256);

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Loopback stand-in for uart_tx/uart_rx plus a standard-mode 256x8 FIFO
    always @(posedge sys_clk) begin
        cyc       <= cyc + 1;
        prev_rx   <= rx_done;
        prev_busy <= tx_busy;
        if (clr) begin
            tx_busy <= 1'b0; busy_cnt <= 0; lb_cnt <= 0; lb_on <= 1'b0; lb_byte <= 8'h00;
            rx_done <= 1'b0; rx_data <= 8'h00; wp <= '0; rp <= '0; fifo_dout <= 8'h00;
            wr_cnt <= 0; rd_cnt <= 0; txen_cnt <= 0; done_cnt <= 0;
            din_err <= 0; lat_err <= 0; txb_err <= 0; txen_cyc <= 0; done_cyc <= 0; rx_cyc <= 0;
        end else begin
            tx_busy <= (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            rx_done <= 1'b0;
            if (lb_cnt != 0) begin
                lb_cnt <= lb_cnt - 1;
                if (lb_cnt == 1 && lb_on) begin
                    rx_done <= 1'b1;
                    rx_data <= lb_byte;
                end
            end
            if (tx_en) begin
                busy_cnt <= TX_BUSY;
                lb_cnt   <= LB_DELAY;
                lb_byte  <= tx_data;
                lb_on    <= (txen_cnt < stop_after);
                txen_cnt <= txen_cnt + 1;
                txen_cyc <= cyc;
                if (txen_cnt < 4) txlog[txen_cnt] <= tx_data;
                if (prev_busy) txb_err <= txb_err + 1;
            end
            if (rx_done) rx_cyc <= cyc;
            if (fifo_wr_en) begin
                if (fifo_din != exp_seed + 8'(wr_cnt)) din_err <= din_err + 1;
                if (!prev_rx) lat_err <= lat_err + 1;
                if (wr_cnt != drop_idx) begin
                    mem[wp[7:0]] <= (wr_cnt == corrupt_idx) ? corrupt_val : fifo_din;
                    wp <= wp + 9'd1;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (fifo_rd_en) begin
                fifo_dout <= mem[rp[7:0]];
                rp        <= rp + 9'd1;
                rd_cnt    <= rd_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic run_test(input bit use_b, input int stop_n, input int corr, input int drop,
                            input int full_n, input int restart_at, input int limit, input string tag);
        sel         = use_b;
        exp_seed    = use_b ? 8'hFE : 8'h00;
        stop_after  = stop_n;
        corrupt_idx = corr;
        drop_idx    = drop;
        full_at     = full_n;
        @(negedge sys_clk); clr = 1'b1;
        @(negedge sys_clk); clr = 1'b0;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge sys_clk);
        start_a = 1'b0; start_b = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        if (restart_at > 0) begin
            repeat (restart_at) @(negedge sys_clk);
            start_b = 1'b1;
            @(negedge sys_clk);
            start_b = 1'b0;
        end
        wait_done(limit, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sys_rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; clr = 1'b1;
        stop_after = 1000; corrupt_idx = -1; drop_idx = -1; full_at = -1;
        corrupt_val = 8'h5A; exp_seed = 8'h00;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("reset_outputs", {tx_en, tx_data, fifo_wr_en, fifo_din, fifo_rd_en, busy, done,
                              pass, err_cnt, err_code}, 64'd0);

        run_test(1'b0, 1000, -1, -1, -1, 0, 20000, "full");
        chk("full_pass", 64'(pass), 64'd1);
        chk("full_err_cnt", 64'(err_cnt), 64'd0);
        chk("full_err_code", 64'(err_code), 64'd0);
        chk("full_busy_at_done", 64'(busy), 64'd0);
        @(negedge sys_clk);
        chk("full_done_pulse", 64'(done), 64'd0);
        chk("full_writes", 64'(wr_cnt), 64'd256);
        chk("full_reads", 64'(rd_cnt), 64'd256);
        chk("full_din_pattern", 64'(din_err), 64'd0);
        chk("full_wr_latency", 64'(lat_err), 64'd0);
        chk("full_tx_vs_busy", 64'(txb_err), 64'd0);

        run_test(1'b0, 1000, 10, -1, -1, 0, 20000, "corrupt");
        chk("corrupt_pass", 64'(pass), 64'd0);
        chk("corrupt_err_cnt", 64'(err_cnt), 64'd1);
        chk("corrupt_err_code", 64'(err_code), 64'd0);
        @(negedge sys_clk);
        chk("corrupt_reads", 64'(rd_cnt), 64'd256);

        run_test(1'b0, 5, -1, -1, -1, 0, 5000, "timeout");
        chk("timeout_err_code", 64'(err_code), 64'd1);
        chk("timeout_pass", 64'(pass), 64'd0);
        @(negedge sys_clk);
        chk("timeout_writes", 64'(wr_cnt), 64'd5);
        chk("timeout_txens", 64'(txen_cnt), 64'd6);
        chk("timeout_latency", 64'(done_cyc - txen_cyc), 64'd1001);

        run_test(1'b0, 1000, -1, -1, 2, 0, 2000, "ovf");
        chk("ovf_err_code", 64'(err_code), 64'd2);
        chk("ovf_pass", 64'(pass), 64'd0);
        @(negedge sys_clk);
        chk("ovf_writes", 64'(wr_cnt), 64'd2);
        chk("ovf_done_latency", 64'(done_cyc - rx_cyc), 64'd2);
        chk("ovf_reads", 64'(rd_cnt), 64'd0);

        run_test(1'b1, 1000, -1, 2, -1, 0, 2000, "unf");
        chk("unf_err_code", 64'(err_code), 64'd3);
        chk("unf_err_cnt", 64'(err_cnt), 64'd1);
        chk("unf_pass", 64'(pass), 64'd0);
        @(negedge sys_clk);
        chk("unf_reads", 64'(rd_cnt), 64'd3);

        run_test(1'b1, 1000, -1, -1, -1, 30, 2000, "seedfe");
        chk("seedfe_pass", 64'(pass), 64'd1);
        chk("seedfe_err_cnt", 64'(err_cnt), 64'd0);
        chk("seedfe_err_code", 64'(err_code), 64'd0);
        repeat (200) @(negedge sys_clk);
        chk("seedfe_byte0", 64'(txlog[0]), 64'hFE);
        chk("seedfe_byte1", 64'(txlog[1]), 64'hFF);
        chk("seedfe_byte2", 64'(txlog[2]), 64'h00);
        chk("seedfe_byte3", 64'(txlog[3]), 64'h01);
        chk("seedfe_txens", 64'(txen_cnt), 64'd4);
        chk("seedfe_done_cnt", 64'(done_cnt), 64'd1);

        // asynchronous reset while waiting for the second looped-back byte
        @(negedge sys_clk); clr = 1'b1;
        @(negedge sys_clk); clr = 1'b0;
        start_b = 1'b1;
        @(negedge sys_clk); start_b = 1'b0;
        begin
            int n = 0;
            while (txen_cnt < 2 && n < 500) begin
                @(negedge sys_clk);
                n++;
            end
        end
        chk("rst_reached_tx2", 64'(txen_cnt), 64'd2);
        repeat (3) @(negedge sys_clk);
        chk("rst_busy_before", 64'(busy), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {tx_en, tx_data, fifo_wr_en, fifo_din, fifo_rd_en, busy, done,
                                pass, err_cnt, err_code}, 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (50) @(negedge sys_clk);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk("rst_stray_rx_ignored", 64'(wr_cnt), 64'd1);
        chk("rst_stays_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
